conv_core: RTL and testbench

- Compute engine that sits directly downstream of the AIP register/memory wrapper in the IP_MOD_CONV IP.
- After start, reads the X and Y input memories (synchronous RAMs, 1-cycle read latency) and computes the discrete convolution z[n] = sum x[k]*y[n-k].
- Writes results into the Z output memory, then pulses done, which the wrapper turns into the Done interrupt flag (bit 0).

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_mac.sv | 56 +++++
 rtl/conv_core.sv | 175 +++++++++++++++++
 tb/tb_conv_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the IP_MOD_CONV compute engine.
// Optional macro CONV_SAT_EN (see conv_mac) selects saturating result words.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FETCH,
    DRAIN,
    WRITE,
    FIN
  } conv_state_e;

  localparam logic SHAPE_FULL = 1'b1;
  localparam logic SHAPE_SAME = 1'b0;

  // Field offsets of the wrapper's conf register
  localparam int SIZE_Y_LSB = 0;
  localparam int SIZE_X_LSB = 5;
  localparam int SHAPE_BIT  = 10;

  // Accumulator width: full product plus enough guard bits for 2^aw terms
  function automatic int acc_width(input int dw, input int aw);
    return 2 * dw + aw + 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered signed product followed by a wide accumulator.
// CONV_SAT_EN defined: result clamps to the signed DATA_WIDTH range;
// undefined: result is the low DATA_WIDTH bits of the accumulator.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_AW      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         vld_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic        [DATA_WIDTH-1:0] res_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, IN_AW);
  localparam int PW    = 2 * DATA_WIDTH;

  logic signed [PW-1:0]    prod_q;
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] acc_q;

  // Product stage then accumulate; clear also drops any in-flight product
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_vld_q <= vld_i;
      if (vld_i)      prod_q <= a_i * b_i;
      if (prod_vld_q) acc_q  <= acc_q + ACC_W'(prod_q);
    end
  end

`ifdef CONV_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic ovf;

  // Out of range when the bits above the result sign differ from the acc sign
  always_comb begin
    ovf = acc_q[ACC_W-1:DATA_WIDTH-1] != {(ACC_W-DATA_WIDTH+1){acc_q[ACC_W-1]}};
    res_o = acc_q[DATA_WIDTH-1:0];
    if (ovf) res_o = acc_q[ACC_W-1] ? SMIN : SMAX;
  end
`else
  logic acc_hi_unused;
  assign acc_hi_unused = ^acc_q[ACC_W-1:DATA_WIDTH];
  assign res_o = acc_q[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/conv_core.sv
// conv_core: discrete convolution z[n] = sum x[k]*y[n-k] over synchronous
// X/Y RAMs, results written to Z RAM, then a one-cycle done pulse.
// Optional macro CONV_SAT_EN makes z_wdata saturate instead of wrap.
module conv_core
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_AW      = 5,
  parameter int OUT_AW     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_AW-1:0]      size_x,
  input  logic [IN_AW-1:0]      size_y,
  input  logic                  shape,
  output logic [IN_AW-1:0]      x_addr,
  input  logic [DATA_WIDTH-1:0] x_rdata,
  output logic [IN_AW-1:0]      y_addr,
  input  logic [DATA_WIDTH-1:0] y_rdata,
  output logic [OUT_AW-1:0]     z_addr,
  output logic [DATA_WIDTH-1:0] z_wdata,
  output logic                  z_we,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_AW-1:0]     z_len
);

  conv_state_e           state_q;
  logic [IN_AW-1:0]      nx_q, ny_q, k_q, kmax_q;
  logic                  shape_q;
  logic [OUT_AW-1:0]     lz_q, zi_q, n_q, z_addr_q, z_len_q;
  logic [1:0]            dcnt_q;
  logic                  rd_vld_q, z_we_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] z_wdata_q, mac_res;
  logic [OUT_AW-1:0]     lz_c, off_c, n_nx;

  // First contributing k for output n: max(0, n-Ny+1)
  function automatic logic [IN_AW-1:0] f_kmin(input logic [OUT_AW-1:0] n,
                                               input logic [IN_AW-1:0]  ny);
    logic [OUT_AW:0] n1;
    n1 = {1'b0, n} + (OUT_AW+1)'(1);
    if (n1 > (OUT_AW+1)'(ny)) return IN_AW'(n1 - (OUT_AW+1)'(ny));
    return '0;
  endfunction

  // Last contributing k for output n: min(n, Nx-1)
  function automatic logic [IN_AW-1:0] f_kmax(input logic [OUT_AW-1:0] n,
                                               input logic [IN_AW-1:0]  nx);
    if (n < OUT_AW'(nx)) return IN_AW'(n);
    return nx - IN_AW'(1);
  endfunction

  // Output length and starting index from the latched configuration
  always_comb begin
    lz_c  = OUT_AW'(nx_q);
    off_c = OUT_AW'(ny_q >> 1);
    if (shape_q == SHAPE_FULL) begin
      lz_c  = OUT_AW'(nx_q) + OUT_AW'(ny_q) - OUT_AW'(1);
      off_c = '0;
    end
    n_nx = n_q + OUT_AW'(1);
  end

  // Control FSM: index counters, pipeline valid and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nx_q      <= '0;
      ny_q      <= '0;
      shape_q   <= 1'b0;
      lz_q      <= '0;
      zi_q      <= '0;
      n_q       <= '0;
      k_q       <= '0;
      kmax_q    <= '0;
      dcnt_q    <= '0;
      rd_vld_q  <= 1'b0;
      z_we_q    <= 1'b0;
      z_addr_q  <= '0;
      z_wdata_q <= '0;
      z_len_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      z_we_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= (state_q == FETCH);
      case (state_q)
        IDLE: if (start) begin
          nx_q    <= size_x;
          ny_q    <= size_y;
          shape_q <= shape;
          busy_q  <= 1'b1;
          state_q <= SETUP;
        end
        SETUP: begin
          zi_q <= '0;
          if (nx_q == '0 || ny_q == '0) begin
            lz_q    <= '0;
            z_len_q <= '0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            lz_q    <= lz_c;
            n_q     <= off_c;
            k_q     <= f_kmin(off_c, ny_q);
            kmax_q  <= f_kmax(off_c, nx_q);
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (k_q == kmax_q) begin
            dcnt_q  <= '0;
            state_q <= DRAIN;
          end else begin
            k_q <= k_q + IN_AW'(1);
          end
        end
        // Wait for the last term to pass the product and accumulate stages
        DRAIN: begin
          if (dcnt_q == 2'd2) begin
            z_we_q    <= 1'b1;
            z_addr_q  <= zi_q;
            z_wdata_q <= mac_res;
            state_q   <= WRITE;
          end else begin
            dcnt_q <= dcnt_q + 2'd1;
          end
        end
        WRITE: begin
          if (zi_q == lz_q - OUT_AW'(1)) begin
            done_q  <= 1'b1;
            z_len_q <= lz_q;
            state_q <= FIN;
          end else begin
            zi_q    <= zi_q + OUT_AW'(1);
            n_q     <= n_nx;
            k_q     <= f_kmin(n_nx, ny_q);
            kmax_q  <= f_kmax(n_nx, nx_q);
            state_q <= FETCH;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_addr  = k_q;
  assign y_addr  = IN_AW'(n_q - OUT_AW'(k_q));
  assign z_addr  = z_addr_q;
  assign z_wdata = z_wdata_q;
  assign z_we    = z_we_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign z_len   = z_len_q;

  conv_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .IN_AW     (IN_AW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == SETUP || state_q == WRITE),
    .vld_i(rd_vld_q),
    .a_i  ($signed(x_rdata)),
    .b_i  ($signed(y_rdata)),
    .res_o(mac_res)
  );

endmodule

// File: tb/tb_conv_core.sv
// tb_conv_core: scoreboard bench for conv_core with behavioural X/Y/Z RAMs.
module tb_conv_core;
  localparam int DW  = 32;
  localparam int IAW = 5;
  localparam int OAW = 6;
  localparam logic signed [71:0] SMAX = 72'sh7FFFFFFF;
  localparam logic signed [71:0] SMIN = -72'sh80000000;

  logic           clk = 1'b0;
  logic           rst, start, shape;
  logic [IAW-1:0] size_x, size_y, x_addr, y_addr;
  logic [DW-1:0]  x_rdata, y_rdata, z_wdata;
  logic [OAW-1:0] z_addr, z_len;
  logic           z_we, busy, done;

  logic [DW-1:0] xmem [32];
  logic [DW-1:0] ymem [32];
  logic [DW-1:0] zmem [64];

  typedef struct {
    logic [OAW-1:0] a;
    logic [DW-1:0]  d;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  conv_core #(.DATA_WIDTH(DW), .IN_AW(IAW), .OUT_AW(OAW)) dut (
    .clk(clk), .rst(rst), .start(start), .size_x(size_x), .size_y(size_y),
    .shape(shape), .x_addr(x_addr), .x_rdata(x_rdata), .y_addr(y_addr),
    .y_rdata(y_rdata), .z_addr(z_addr), .z_wdata(z_wdata), .z_we(z_we),
    .busy(busy), .done(done), .z_len(z_len)
  );

  always #5 clk = ~clk;

  // Synchronous-read input memories
  always @(posedge clk) begin
    x_rdata <= xmem[x_addr];
    y_rdata <= ymem[y_addr];
  end

  // Z memory + scoreboard check of every write
  always @(negedge clk) begin : mon
    exp_t e;
    if (z_we === 1'b1) begin
      zmem[z_addr] = z_wdata;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%h", z_addr, z_wdata);
      end else begin
        e = sbq.pop_front();
        if (z_addr !== e.a || z_wdata !== e.d) begin
          bad++;
          $display("FAIL z_write got addr=%0d data=%h want addr=%0d data=%h",
                   z_addr, z_wdata, e.a, e.d);
        end
      end
    end
  end

  function automatic logic [DW-1:0] fold(input logic signed [71:0] s);
`ifdef CONV_SAT_EN
    if (s > SMAX) return 32'h7FFFFFFF;
    if (s < SMIN) return 32'h80000000;
`endif
    return s[DW-1:0];
  endfunction

  // Golden convolution: pushes expected writes, returns length and latency
  task automatic push_golden(input int nx, input int ny, input logic shp,
                             output int lz, output int cyc);
    int off, n, terms;
    logic signed [71:0] s;
    exp_t e;
    lz  = shp ? nx + ny - 1 : nx;
    off = shp ? 0 : ny / 2;
    if (nx == 0 || ny == 0) lz = 0;
    cyc = 2;
    for (int i = 0; i < lz; i++) begin
      n = i + off;
      s = '0;
      terms = 0;
      for (int k = 0; k < nx; k++)
        if (n - k >= 0 && n - k < ny) begin
          s = s + 72'($signed(xmem[k])) * 72'($signed(ymem[n-k]));
          terms++;
        end
      cyc += terms + 4;
      e.a = OAW'(i);
      e.d = fold(s);
      sbq.push_back(e);
    end
  endtask

  // Start one run and check busy, done latency, done width, z_len, drained queue
  task automatic run(input string nm, input int nx, input int ny, input logic shp,
                     input int exp_cyc, input int exp_len, input bit poke);
    int cyc, extra;
    @(posedge clk); #1;
    size_x = IAW'(nx); size_y = IAW'(ny); shape = shp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s_busy got=%b want=1", nm, busy);
    end
    if (poke) begin
      size_x = '0; size_y = 5'd3; shape = ~shp;
    end
    while (done !== 1'b1 && cyc < 2000) begin
      start = (poke && cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    total++;
    if (cyc != exp_cyc) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, cyc, exp_cyc);
    end
    total++;
    if (z_len !== OAW'(exp_len)) begin
      bad++; $display("FAIL %s_z_len got=%0d want=%0d", nm, z_len, exp_len);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL %s_extra_done got=%0d want=0", nm, extra);
    end
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL %s_missing_writes got=%0d want=0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; size_x = '0; size_y = '0; shape = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, z_we} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000", {busy, done, z_we});
    end
    total++;
    if (z_len !== '0 || z_addr !== '0 || z_wdata !== '0) begin
      bad++; $display("FAIL reset_z got len=%0d addr=%0d data=%h want=0", z_len, z_addr, z_wdata);
    end
    total++;
    if (x_addr !== '0 || y_addr !== '0) begin
      bad++; $display("FAIL reset_addr got x=%0d y=%0d want=0", x_addr, y_addr);
    end
    rst = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) begin xmem[i] = '0; ymem[i] = '0; end
    for (int i = 0; i < 4; i++) xmem[i] = DW'(i + 1);
    for (int i = 0; i < 3; i++) ymem[i] = 32'd1;
  endtask

  // Full mode; a start and config change mid-run must be ignored
  task automatic test_full();
    int lz, cyc;
    int want [6] = '{1, 3, 6, 9, 7, 4};
    load_ramp();
    push_golden(4, 3, 1'b1, lz, cyc);
    run("full", 4, 3, 1'b1, 38, 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (zmem[i] !== DW'(want[i])) begin
        bad++; $display("FAIL full_z%0d got=%0d want=%0d", i, zmem[i], want[i]);
      end
    end
  endtask

  task automatic test_same();
    int lz, cyc;
    load_ramp();
    for (int i = 0; i < 64; i++) zmem[i] = 32'hDEADBEEF;
    push_golden(4, 3, 1'b0, lz, cyc);
    run("same", 4, 3, 1'b0, cyc, 4, 1'b0);
    total++;
    if (zmem[3] !== 32'd7) begin
      bad++; $display("FAIL same_z3 got=%0d want=7", zmem[3]);
    end
    total++;
    if (zmem[4] !== 32'hDEADBEEF || zmem[5] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL same_untouched got=%h %h want=deadbeef", zmem[4], zmem[5]);
    end
  endtask

  task automatic test_random();
    int lz, cyc;
    for (int i = 0; i < 32; i++) begin xmem[i] = $urandom; ymem[i] = $urandom; end
    push_golden(10, 5, 1'b1, lz, cyc);
    run("rand", 10, 5, 1'b1, 108, 14, 1'b0);
  endtask

  task automatic test_sat();
    int lz, cyc;
    xmem[0] = 32'h7FFFFFFF; ymem[0] = 32'd2;
    push_golden(1, 1, 1'b1, lz, cyc);
    run("sat_pos", 1, 1, 1'b1, 7, 1, 1'b0);
    total++;
`ifdef CONV_SAT_EN
    if (zmem[0] !== 32'h7FFFFFFF) begin
      bad++; $display("FAIL sat_pos_z0 got=%h want=7fffffff", zmem[0]);
    end
`else
    if (zmem[0] !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL sat_pos_z0 got=%h want=fffffffe", zmem[0]);
    end
`endif
    xmem[0] = 32'h80000000;
    push_golden(1, 1, 1'b1, lz, cyc);
    run("sat_neg", 1, 1, 1'b1, 7, 1, 1'b0);
    total++;
`ifdef CONV_SAT_EN
    if (zmem[0] !== 32'h80000000) begin
      bad++; $display("FAIL sat_neg_z0 got=%h want=80000000", zmem[0]);
    end
`else
    if (zmem[0] !== 32'h00000000) begin
      bad++; $display("FAIL sat_neg_z0 got=%h want=00000000", zmem[0]);
    end
`endif
  endtask

  task automatic test_empty();
    run("empty", 0, 3, 1'b1, 2, 0, 1'b0);
  endtask

  // Reset during FETCH aborts the run; a following start completes normally
  task automatic test_reset_mid_run();
    int lz, cyc, dcnt;
    load_ramp();
    ymem[3] = 32'd5; ymem[4] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    size_x = 5'd4; size_y = 5'd5; shape = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || z_we !== 1'b0) begin
      bad++; $display("FAIL abort_state got busy=%b we=%b want=0 0", busy, z_we);
    end
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
    end
    total++;
    if (dcnt != 0) begin
      bad++; $display("FAIL abort_done got=%0d want=0", dcnt);
    end
    push_golden(4, 5, 1'b0, lz, cyc);
    run("after_abort", 4, 5, 1'b0, cyc, 4, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin xmem[i] = '0; ymem[i] = '0; end
    for (int i = 0; i < 64; i++) zmem[i] = '0;
    test_reset();
    test_full();
    test_same();
    test_random();
    test_sat();
    test_empty();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
